// File: rtl/mux_scan_nx1.sv
// N:1 registered channel mux with manual capture and scan sweep modes.
// Ports: clk, rst, in[N*WIDTH], s, mode, in_valid/in_ready, start,
//   out, out_ch, out_valid/out_ready, done; out_par if MUX_SCAN_PARITY_EN.
module mux_scan_nx1 #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [(2**SEL_W)*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]            s,
  input  logic                        mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        start,
  output logic [WIDTH-1:0]            out,
  output logic [SEL_W-1:0]            out_ch,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        done
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                        out_par
`endif
);

  localparam int N = 2**SEL_W;
  localparam logic [SEL_W-1:0] LAST = '1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [SEL_W-1:0] idx;
  logic             last;
  logic             free;
  logic             load;
  logic [SEL_W-1:0] load_sel;
  logic [WIDTH-1:0] ch [N];

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign ch[k] = in[k*WIDTH +: WIDTH];
  end

  always_comb begin
    free     = ~out_valid | out_ready;
    in_ready = (state == IDLE) & free;
    load     = 1'b0;
    load_sel = '0;
    unique case (state)
      IDLE: begin
        if (in_ready) begin
          if (!mode && in_valid) begin
            load     = 1'b1;
            load_sel = s;
          end else if (mode && start) begin
            load     = 1'b1;
            load_sel = '0;
          end
        end
      end
      SCAN: begin
        // once the last channel is loaded, only its drain remains
        if (free && !last) begin
          load     = 1'b1;
          load_sel = idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      last      <= 1'b0;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (load) begin
        out       <= ch[load_sel];
        out_ch    <= load_sel;
        out_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
        out_par   <= ^ch[load_sel];
`endif
      end else if (free) begin
        out_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (load && mode) begin
            state <= SCAN;
            idx   <= SEL_W'(1);
            last  <= 1'b0;
          end
        end
        SCAN: begin
          if (load) begin
            if (idx == LAST) last <= 1'b1;
            else             idx  <= idx + 1'b1;
          end else if (last && free) begin
            // final word transferred this cycle
            done  <= 1'b1;
            state <= IDLE;
            idx   <= '0;
            last  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed self-checking bench for mux_scan_nx1 (WIDTH=8, SEL_W=3).
// Table-driven manual captures plus hand sequences for scan corner cases.
module tb_mux_scan_nx1;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_bus;
  logic [2:0]  s;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic        start;
  logic [7:0]  out;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic        done;
`ifdef MUX_SCAN_PARITY_EN
  logic        out_par;
`endif

  int errors = 0;
  int checks = 0;

  mux_scan_nx1 #(.WIDTH(8), .SEL_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .in(in_bus),
    .s(s),
    .mode(mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .start(start),
    .out(out),
    .out_ch(out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .done(done)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .out_par(out_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t tv [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 8; k++) in_bus[k*8 +: 8] = 8'h10 + 8'(k);
  endtask

  task automatic manual(input logic [2:0] sel, input logic [7:0] d,
                        input logic p);
    in_bus = '0;
    in_bus[sel*8 +: 8] = d;
    s = sel;
    mode = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_bus[sel*8 +: 8] = ~d;
    #1;
    check("man_out", 32'(out), 32'(d));
    check("man_ch", 32'(out_ch), 32'(sel));
    check("man_vld", 32'(out_valid), 1);
`ifdef MUX_SCAN_PARITY_EN
    check("man_par", 32'(out_par), 32'(p));
`else
    if (p === 1'bx) $display("unused");
`endif
    tick();
    check("man_vld_clr", 32'(out_valid), 0);
  endtask

  initial begin
    tv[0] = '{3'd5, 8'hA5, 1'b0};
    tv[1] = '{3'd0, 8'h00, 1'b0};
    tv[2] = '{3'd7, 8'hFF, 1'b0};
    tv[3] = '{3'd3, 8'h07, 1'b1};
    tv[4] = '{3'd6, 8'h03, 1'b0};
    tv[5] = '{3'd1, 8'h80, 1'b1};

    rst = 1'b1;
    in_bus = '0;
    s = '0;
    mode = 1'b0;
    in_valid = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_vld", 32'(out_valid), 0);
    check("rst_out", 32'(out), 0);
    check("rst_ch", 32'(out_ch), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rdy", 32'(in_ready), 1);
    rst = 1'b0;
    tick();

    // manual captures
    foreach (tv[i]) manual(tv[i].sel, tv[i].data, tv[i].par);

    // start ignored in manual mode, in_valid ignored in scan mode
    load_ramp();
    mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_m0", 32'(out_valid), 0);
    mode = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("inv_m1", 32'(out_valid), 0);

    // full scan
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("scan_out", 32'(out), 32'h10 + k);
      check("scan_ch", 32'(out_ch), k);
      check("scan_done0", 32'(done), 0);
      tick();
    end
    check("scan_done", 32'(done), 1);
    check("scan_vld_end", 32'(out_valid), 0);
    tick();
    check("scan_done_pulse", 32'(done), 0);
    check("scan_rdy_end", 32'(in_ready), 1);

    // stall at channel 2, blocking in_valid and mode change at 4
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("stl_out", 32'(out), 32'h10 + k);
      check("stl_ch", 32'(out_ch), k);
      if (k == 2) begin
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          in_bus[3*8 +: 8] = 8'hEE;
          tick();
          check("stl_hold", 32'(out), 32'h12);
          check("stl_hold_ch", 32'(out_ch), 2);
          check("stl_rdy", 32'(in_ready), 0);
        end
        load_ramp();
        out_ready = 1'b1;
      end
      if (k == 4) begin
        mode = 1'b0;
        s = 3'd6;
        in_valid = 1'b1;
        #1;
        check("blk_rdy", 32'(in_ready), 0);
      end
      if (k == 6) in_valid = 1'b0;
      tick();
    end
    check("stl_done", 32'(done), 1);
    tick();
    mode = 1'b1;

    // reset mid-sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("rmid_ch", 32'(out_ch), 4);
    rst = 1'b1;
    #1;
    check("rmid_vld", 32'(out_valid), 0);
    check("rmid_out", 32'(out), 0);
    tick();
    rst = 1'b0;
    tick();
    check("rmid_rdy", 32'(in_ready), 1);
    for (int j = 0; j < 10; j++) begin
      check("rmid_nodone", 32'(done), 0);
      tick();
    end
    manual(3'd2, 8'h5C, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
